// File: rtl/l2_argmax.sv
// Argmax stage after the L2 fully-connected layer: captures ten class scores,
// scans them one per cycle, and offers the winning digit on a valid/ready port.
module l2_argmax #(
    parameter int unsigned SIGNED_SCORES = 1,
    parameter int unsigned FRAME_CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   l2_done,
    input  logic [7:0]             num_0,
    input  logic [7:0]             num_1,
    input  logic [7:0]             num_2,
    input  logic [7:0]             num_3,
    input  logic [7:0]             num_4,
    input  logic [7:0]             num_5,
    input  logic [7:0]             num_6,
    input  logic [7:0]             num_7,
    input  logic [7:0]             num_8,
    input  logic [7:0]             num_9,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [3:0]             digit,
    output logic [7:0]             max_score,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_HOLD,
        S_REARM
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_capture;
    logic                   w_gt;
    logic                   w_last;
    logic [7:0]             w_cand;

    logic [7:0]             r_buf [10];
    logic [3:0]             r_idx;
    logic [3:0]             r_best_idx;
    logic [7:0]             r_best_val;
    logic                   r_busy;
    logic                   r_valid;
    logic [3:0]             r_digit;
    logic [7:0]             r_max;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    assign busy         = r_busy;
    assign result_valid = r_valid;
    assign digit        = r_digit;
    assign max_score    = r_max;
    assign frame_cnt    = r_frame_cnt;

    assign w_cand = r_buf[r_idx];
    assign w_last = (r_idx == 4'd9);

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        if (SIGNED_SCORES != 0) begin
            w_gt = $signed(w_cand) > $signed(r_best_val);
        end else begin
            w_gt = w_cand > r_best_val;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (l2_done) begin
                    w_next    = S_SCAN;
                    w_capture = 1'b1;
                end
            end
            S_SCAN: begin
                if (w_last) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (result_ready) begin
                    w_next = l2_done ? S_REARM : S_IDLE;
                end
            end
            S_REARM: begin
                if (!l2_done) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Status flags are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_busy  <= (w_next == S_SCAN) || (w_next == S_HOLD);
            r_valid <= (w_next == S_HOLD);
            if (r_state == S_HOLD && result_ready) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 10; i++) begin
                r_buf[i] <= '0;
            end
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
            r_digit    <= '0;
            r_max      <= '0;
        end else if (w_capture) begin
            r_buf[0]   <= num_0;
            r_buf[1]   <= num_1;
            r_buf[2]   <= num_2;
            r_buf[3]   <= num_3;
            r_buf[4]   <= num_4;
            r_buf[5]   <= num_5;
            r_buf[6]   <= num_6;
            r_buf[7]   <= num_7;
            r_buf[8]   <= num_8;
            r_buf[9]   <= num_9;
            r_best_val <= num_0;
            r_best_idx <= '0;
            r_idx      <= 4'd1;
        end else if (r_state == S_SCAN) begin
            if (w_gt) begin
                r_best_val <= w_cand;
                r_best_idx <= r_idx;
            end
            r_idx <= r_idx + 4'd1;
            // The last compare is folded straight into the published result.
            if (w_last) begin
                r_digit <= w_gt ? r_idx : r_best_idx;
                r_max   <= w_gt ? w_cand : r_best_val;
            end
        end
    end

endmodule

// File: doc/l2_argmax.md
# l2_argmax

Classification stage directly downstream of the L2 fully-connected controller. When the L2 stage signals completion, this block captures its ten 8-bit class scores (num_0..num_9) in one cycle. It scans them sequentially to find the maximum and presents the winning digit and its score on a valid/ready output handshake to the SoC-facing register or bus interface.

## Interface
Parameters:
- SIGNED_SCORES, 1, 1 = scores compared as two's-complement signed; 0 = unsigned.
- FRAME_CNT_W, 8, width of the wrapping completed-classification counter.

Ports (one clock; reset is asynchronous and active-low):
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- l2_done, input, 1, level completion flag from the L2 stage. It stays high until the L2 stage's own valid drops.
- num_0 .. num_9, input, 8 each, class scores; sampled only in the capture cycle.
- busy, output, 1, high in SCAN and HOLD.
- result_valid, output, 1, result available (HOLD state).
- result_ready, input, 1, consumer accepts the result.
- digit, output, 4, index (0..9) of the maximum score.
- max_score, output, 8, value of the maximum score.
- frame_cnt, output, FRAME_CNT_W, count of accepted results; wraps.

## Operation
- States: IDLE, SCAN, HOLD, REARM.
- Reset values: state=IDLE, busy=0, result_valid=0, digit=0, max_score=0, frame_cnt=0, score buffer=0, idx=0.
- IDLE, l2_done=1: capture edge.
  - num_0..num_9 are latched into an internal 10x8 buffer.
  - best_val is set to num_0, best_idx to 0, idx to 1.
  - State goes to SCAN.
- IDLE, l2_done=0: remain in IDLE.
- SCAN, one compare per cycle:
  - If buf[idx] > best_val (strict), best_val and best_idx are updated to buf[idx] and idx.
  - idx increments.
  - After the idx=9 compare, digit and max_score are loaded from the final best and state goes to HOLD.
- Comparison mode:
  - SIGNED_SCORES=1: 8-bit signed compare, so 0x80 is the smallest value.
  - SIGNED_SCORES=0: unsigned compare.
- Ties: the lowest index wins.
- HOLD: result_valid=1. digit and max_score are stable.
- HOLD, result_ready=1: transfer.
  - frame_cnt increments, wrapping from all-ones to 0.
  - If l2_done=1 in that cycle, state goes to REARM; otherwise to IDLE.
- REARM: wait for l2_done=0, then go to IDLE. This prevents recapturing the same L2 frame while the flag is still held.
- digit and max_score keep their last value after transfer until the next SCAN completes.
- Input changes: num_x and l2_done changes during SCAN or HOLD are ignored. The buffer is never reloaded outside the capture edge.

## Timing
- Latency: the capture edge is at cycle T. SCAN occupies T+1..T+9. result_valid rises after the edge ending T+9 and is high from cycle T+10.
- Minimum frame period, with result_ready tied high and l2_done dropping before transfer: 11 cycles. Capture T, accept at T+10, IDLE at T+11.
- result_valid is registered, with no combinational path from result_ready. It falls on the edge following the cycle where result_valid and result_ready are both high.
- busy is registered. It goes high the cycle after the capture edge and low the cycle after transfer.
- l2_done high in the same cycle as transfer leads to REARM. At least one cycle of l2_done=0 is then required before the next capture.
- Asynchronous reset mid-SCAN or mid-HOLD: immediately returns all outputs to their reset values. The in-flight result is discarded and frame_cnt clears.
- After reset release with l2_done already high, capture happens on the first clock edge (state is IDLE).

## Test plan
- Basic argmax:
  - Stimulus: scores {5,3,9,1,0,2,7,4,8,6}, l2_done pulsed, result_ready=1.
  - Required: result_valid from capture+10, digit=2, max_score=9, frame_cnt=1.
- Tie and signed:
  - Stimulus: SIGNED_SCORES=1, all scores 0x80 except num_4=num_7=0x10.
  - Required: digit=4, max_score=0x10.
  - Repeat with SIGNED_SCORES=0 and all scores 0x80: required digit=0, max_score=0x80.
- Backpressure:
  - Stimulus: hold result_ready=0 for 20 cycles after result_valid while changing num_x every cycle.
  - Required: result_valid stays 1; digit and max_score are unchanged; transfer occurs on the first cycle with result_ready=1.
- Held l2_done:
  - Stimulus: l2_done kept high for 50 cycles, result_ready=1.
  - Required: exactly one result; state stays in REARM; a new capture occurs only after l2_done drops then rises; frame_cnt=1 before the re-rise.
- Reset mid-scan:
  - Stimulus: assert rst_n=0 at capture+5.
  - Required: busy=0, result_valid=0, digit=0, frame_cnt=0 immediately, with no result emitted.
  - Then stimulate scores with max at num_9: required digit=9 after a fresh capture.
- Counter wrap:
  - Stimulus: FRAME_CNT_W=8, run 256 back-to-back frames.
  - Required: frame_cnt returns to 0; each frame's digit matches the reference model.
